// File: rtl/sfx_pkg.sv
// sfx_pkg: shared definitions for the sound-effect player.
//   - sound_e      : sound IDs as driven on soundselector by gamestate.
//   - NOTE_*       : note frequencies in Hz.
//   - MAX_NOTES    : longest sequence length.
//   - half_period(): clocks per half-cycle of a square wave, saturated to 17 bits.
package sfx_pkg;

  typedef enum logic [1:0] {
    UI_PRESS    = 2'd0,
    NEXTLEVEL   = 2'd1,
    CRASH       = 2'd2,
    CELEBRATION = 2'd3
  } sound_e;

  localparam int unsigned NOTE_C4 = 262;
  localparam int unsigned NOTE_E4 = 330;
  localparam int unsigned NOTE_G4 = 392;
  localparam int unsigned NOTE_C5 = 523;
  localparam int unsigned NOTE_E5 = 659;
  localparam int unsigned NOTE_G5 = 784;
  localparam int unsigned NOTE_C6 = 1047;

  localparam int unsigned MAX_NOTES = 4;
  localparam int unsigned HALF_W    = 17;

  // Evaluated at elaboration only; a half-period wider than the tone counter saturates.
  function automatic logic [HALF_W-1:0] half_period(input int unsigned clk_hz,
                                                    input int unsigned freq_hz);
    int unsigned h;
    h = clk_hz / (2 * freq_hz);
    if (h > 32'h1FFFF) half_period = 17'h1FFFF;
    else               half_period = h[HALF_W-1:0];
  endfunction

endpackage

// File: rtl/sfx_rom.sv
// sfx_rom: combinational note table for each sound effect.
// Ports:
//   i_sel  [1:0]  - latched sound ID (sound_e encoding)
//   i_idx  [1:0]  - note index within the sequence
//   o_half [16:0] - half-period in clocks of the selected note (0 = rest / out of range)
//   o_last        - high when i_idx is the final note of the sequence
module sfx_rom
  import sfx_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 25_125_000
) (
  input  logic [1:0]        i_sel,
  input  logic [1:0]        i_idx,
  output logic [HALF_W-1:0] o_half,
  output logic              o_last
);

  localparam logic [HALF_W-1:0] H_C4 = half_period(CLK_FREQ_HZ, NOTE_C4);
  localparam logic [HALF_W-1:0] H_E4 = half_period(CLK_FREQ_HZ, NOTE_E4);
  localparam logic [HALF_W-1:0] H_G4 = half_period(CLK_FREQ_HZ, NOTE_G4);
  localparam logic [HALF_W-1:0] H_C5 = half_period(CLK_FREQ_HZ, NOTE_C5);
  localparam logic [HALF_W-1:0] H_E5 = half_period(CLK_FREQ_HZ, NOTE_E5);
  localparam logic [HALF_W-1:0] H_G5 = half_period(CLK_FREQ_HZ, NOTE_G5);
  localparam logic [HALF_W-1:0] H_C6 = half_period(CLK_FREQ_HZ, NOTE_C6);

  always_comb begin
    o_half = '0;
    o_last = 1'b0;
    case (sound_e'(i_sel))
      UI_PRESS: begin
        if (i_idx == 2'd0) o_half = H_C6;
        o_last = (i_idx == 2'd0);
      end
      NEXTLEVEL: begin
        case (i_idx)
          2'd0:    o_half = H_C5;
          2'd1:    o_half = H_E5;
          2'd2:    o_half = H_G5;
          default: o_half = '0;
        endcase
        o_last = (i_idx == 2'd2);
      end
      CRASH: begin
        case (i_idx)
          2'd0:    o_half = H_G4;
          2'd1:    o_half = H_E4;
          default: o_half = H_C4;
        endcase
        o_last = (i_idx == 2'd3);
      end
      default: begin
        case (i_idx)
          2'd0:    o_half = H_C5;
          2'd1:    o_half = H_E5;
          2'd2:    o_half = H_G5;
          default: o_half = H_C6;
        endcase
        o_last = (i_idx == 2'd3);
      end
    endcase
  end

endmodule

// File: rtl/sfx_player.sv
// sfx_player: plays a 1-4 note square-wave sequence on a 1-bit speaker for each game event.
// Optional feature macro: SFX_MUTE_EN (adds i_mute, gating the speaker output only).
// Ports:
//   i_clk                - system (pixel) clock
//   i_reset              - asynchronous active-high reset
//   i_soundselector[1:0] - sound ID, latched on a playsound rising edge
//   i_playsound          - request; each rising edge starts (or restarts) a sequence
//   i_mute               - (SFX_MUTE_EN only) forces the speaker low
//   o_speaker            - square-wave audio
//   o_busy               - high while a sequence, including its gaps, is playing
module sfx_player
  import sfx_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 25_125_000,
  parameter int unsigned NOTE_CYCLES = 2_512_500,
  parameter int unsigned GAP_CYCLES  = 251_250
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_soundselector,
  input  logic       i_playsound,
`ifdef SFX_MUTE_EN
  input  logic       i_mute,
`endif
  output logic       o_speaker,
  output logic       o_busy
);

  localparam int unsigned MAX_CYC = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
  localparam int          CNT_W   = $clog2(MAX_CYC + 1);
  localparam int          IDX_W   = $clog2(MAX_NOTES);

  localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

  state_e              r_state;
  logic [1:0]          r_sel;
  logic [IDX_W-1:0]    r_idx;
  logic [CNT_W-1:0]    r_cnt;    // shared note / gap counter
  logic [HALF_W-1:0]   r_tone;
  logic                r_speaker;
  logic                r_busy;
  logic                r_playsound_q;

  logic                w_trig;
  logic [HALF_W-1:0]   w_half;
  logic                w_last;

  assign w_trig = i_playsound & ~r_playsound_q;

  sfx_rom #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ)
  ) u_rom (
    .i_sel  (r_sel),
    .i_idx  (r_idx),
    .o_half (w_half),
    .o_last (w_last)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= StIdle;
      r_sel         <= '0;
      r_idx         <= '0;
      r_cnt         <= '0;
      r_tone        <= '0;
      r_speaker     <= 1'b0;
      r_busy        <= 1'b0;
      r_playsound_q <= 1'b0;
    end else begin
      r_playsound_q <= i_playsound;
      if (w_trig) begin
        // A new request wins over whatever the sequencer would have done this cycle.
        r_sel     <= i_soundselector;
        r_idx     <= '0;
        r_cnt     <= '0;
        r_tone    <= '0;
        r_speaker <= 1'b0;
        r_busy    <= 1'b1;
        r_state   <= StPlay;
      end else begin
        case (r_state)
          StPlay: begin
            if (r_cnt == NOTE_LAST) begin
              r_speaker <= 1'b0;
              r_cnt     <= '0;
              r_tone    <= '0;
              if (w_last) begin
                r_state <= StIdle;
                r_busy  <= 1'b0;
              end else if (GAP_CYCLES == 0) begin
                r_idx <= r_idx + IDX_W'(1);
              end else begin
                r_state <= StGap;
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
              if (w_half == '0) begin
                r_speaker <= 1'b0;
              end else if (r_tone == w_half - HALF_W'(1)) begin
                r_speaker <= ~r_speaker;
                r_tone    <= '0;
              end else begin
                r_tone <= r_tone + HALF_W'(1);
              end
            end
          end
          StGap: begin
            r_speaker <= 1'b0;
            if (r_cnt == GAP_LAST) begin
              r_idx   <= r_idx + IDX_W'(1);
              r_cnt   <= '0;
              r_tone  <= '0;
              r_state <= StPlay;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: begin
            r_speaker <= 1'b0;
            r_busy    <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef SFX_MUTE_EN
  assign o_speaker = r_speaker & ~i_mute;
`else
  assign o_speaker = r_speaker;
`endif
  assign o_busy = r_busy;

endmodule

// File: tb/tb_sfx_player.sv
// tb_sfx_player: directed self-checking bench for sfx_player.
// Uses CLK_FREQ_HZ=1 MHz, NOTE_CYCLES=2000, GAP_CYCLES=100 so that the expected
// half-periods are C6=477, G5=637, E5=758, C5=956, G4=1275, E4=1515, C4=1908.
module tb_sfx_player;

  localparam int NOTE = 2000;
  localparam int GAP  = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] sel;
  logic       play;
  logic       speaker;
  logic       busy;
`ifdef SFX_MUTE_EN
  logic       mute;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  sfx_player #(
    .CLK_FREQ_HZ(1_000_000),
    .NOTE_CYCLES(NOTE),
    .GAP_CYCLES (GAP)
  ) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_soundselector(sel),
    .i_playsound    (play),
`ifdef SFX_MUTE_EN
    .i_mute         (mute),
`endif
    .o_speaker      (speaker),
    .o_busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [1:0] s);
    sel  = s;
    play = 1'b1;
    tick();
    play = 1'b0;
  endtask

  // Follows a running sequence cycle by cycle from the trigger edge, counting busy cycles,
  // speaker toggles, and cycles where the speaker differs from the expected waveform.
  task automatic observe_seq(input int h0, input int h1, input int h2, input int h3,
                             input int nnotes, input int limit,
                             output int busy_len, output int spk_err, output int toggles);
    int   h[4];
    int   c, note, pos;
    logic prev, exp_spk;
    h[0] = h0; h[1] = h1; h[2] = h2; h[3] = h3;
    c = 0; spk_err = 0; toggles = 0; prev = 1'b0;
    while (busy === 1'b1 && c < limit) begin
      note = c / (NOTE + GAP);
      pos  = c % (NOTE + GAP);
      if (note >= nnotes || pos >= NOTE) exp_spk = 1'b0;
      else exp_spk = ((pos / h[note]) % 2 == 1) ? 1'b1 : 1'b0;
      if (speaker !== exp_spk) spk_err++;
      if (speaker !== prev) toggles++;
      prev = speaker;
      c++;
      tick();
    end
    busy_len = c;
  endtask

  task automatic test_reset();
    int bad;
    reset = 1'b1; play = 1'b0; sel = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (speaker !== 1'b0) begin
      n_fail++; $display("FAIL reset_speaker: got %b expected 0", speaker);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
    reset = 1'b0;
    bad = 0;
    repeat (20) begin
      tick();
      if (busy !== 1'b0 || speaker !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL idle_after_reset: active cycles %0d expected 0", bad);
    end
  endtask

  task automatic test_ui_press();
    int len, err, tog, bad;
    pulse(2'd0);
    observe_seq(477, 0, 0, 0, 1, 3000, len, err, tog);
    n_tests++;
    if (len != 2000) begin
      n_fail++; $display("FAIL ui_busy_len: got %0d expected 2000", len);
    end
    n_tests++;
    if (err != 0) begin
      n_fail++; $display("FAIL ui_waveform: bad cycles %0d expected 0", err);
    end
    n_tests++;
    if (tog != 4) begin
      n_fail++; $display("FAIL ui_toggles: got %0d expected 4", tog);
    end
    n_tests++;
    if (speaker !== 1'b0) begin
      n_fail++; $display("FAIL ui_speaker_end: got %b expected 0", speaker);
    end
    bad = 0;
    repeat (10) begin
      tick();
      if (busy !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL ui_stays_idle: busy cycles %0d expected 0", bad);
    end
  endtask

  task automatic test_celebration();
    int len, err, tog;
    pulse(2'd3);
    sel = 2'd0;  // no trigger: must not affect the running sequence
    observe_seq(956, 758, 637, 477, 4, 10000, len, err, tog);
    n_tests++;
    if (len != 8300) begin
      n_fail++; $display("FAIL celeb_busy_len: got %0d expected 8300", len);
    end
    n_tests++;
    if (err != 0) begin
      n_fail++; $display("FAIL celeb_waveform: bad cycles %0d expected 0", err);
    end
    n_tests++;
    if (speaker !== 1'b0) begin
      n_fail++; $display("FAIL celeb_speaker_end: got %b expected 0", speaker);
    end
  endtask

  task automatic test_level_held();
    int len, err, tog, bad;
    sel  = 2'd1;
    play = 1'b1;
    tick();
    observe_seq(956, 758, 637, 0, 3, 10000, len, err, tog);
    n_tests++;
    if (len != 6200) begin
      n_fail++; $display("FAIL held_busy_len: got %0d expected 6200", len);
    end
    n_tests++;
    if (err != 0) begin
      n_fail++; $display("FAIL held_waveform: bad cycles %0d expected 0", err);
    end
    bad = 0;
    repeat (10000 - 1 - 6200) begin
      tick();
      if (busy !== 1'b0) bad++;
    end
    play = 1'b0;
    tick();
    if (busy !== 1'b0) bad++;
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL held_no_retrigger: busy cycles %0d expected 0", bad);
    end
  endtask

  task automatic test_preempt();
    int len, err, tog;
    pulse(2'd2);
    observe_seq(1275, 1515, 1908, 1908, 4, 3000, len, err, tog);
    n_tests++;
    if (len != 3000) begin
      n_fail++; $display("FAIL preempt_crash_len: got %0d expected 3000", len);
    end
    n_tests++;
    if (err != 0) begin
      n_fail++; $display("FAIL preempt_crash_wave: bad cycles %0d expected 0", err);
    end
    pulse(2'd0);
    observe_seq(477, 0, 0, 0, 1, 5000, len, err, tog);
    n_tests++;
    if (len != 2000) begin
      n_fail++; $display("FAIL preempt_ui_len: got %0d expected 2000", len);
    end
    n_tests++;
    if (err != 0 || tog != 4) begin
      n_fail++;
      $display("FAIL preempt_ui_wave: bad cycles %0d toggles %0d expected 0 and 4", err, tog);
    end
    n_tests++;
    if (speaker !== 1'b0) begin
      n_fail++; $display("FAIL preempt_speaker_end: got %b expected 0", speaker);
    end
  endtask

  task automatic test_reset_mid();
    int w, bad, len, err, tog;
    pulse(2'd0);
    w = 0;
    while (speaker !== 1'b1 && w < 600) begin
      tick();
      w++;
    end
    n_tests++;
    if (speaker !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_speaker_high: got %b expected 1", speaker);
    end
    #3 reset = 1'b1;
    #1;
    n_tests++;
    if (speaker !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_async: speaker %b busy %b expected 0 0", speaker, busy);
    end
    #10 reset = 1'b0;
    bad = 0;
    repeat (50) begin
      tick();
      if (busy !== 1'b0 || speaker !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL rstmid_idle: active cycles %0d expected 0", bad);
    end
    // playsound already high when reset releases must still trigger.
    reset = 1'b1;
    sel   = 2'd0;
    play  = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL rst_release_trig: busy %b expected 1", busy);
    end
    observe_seq(477, 0, 0, 0, 1, 3000, len, err, tog);
    play = 1'b0;
    n_tests++;
    if (len != 2000 || err != 0) begin
      n_fail++;
      $display("FAIL rst_release_seq: len %0d bad cycles %0d expected 2000 0", len, err);
    end
  endtask

`ifdef SFX_MUTE_EN
  task automatic test_mute();
    int len, err, tog;
    mute = 1'b1;
    pulse(2'd0);
    observe_seq(477, 0, 0, 0, 1, 3000, len, err, tog);
    mute = 1'b0;
    n_tests++;
    if (len != 2000) begin
      n_fail++; $display("FAIL mute_busy_len: got %0d expected 2000", len);
    end
    n_tests++;
    if (tog != 0) begin
      n_fail++; $display("FAIL mute_speaker: toggles %0d expected 0", tog);
    end
  endtask
`endif

  initial begin
`ifdef SFX_MUTE_EN
    mute = 1'b0;
`endif
    test_reset();
    test_ui_press();
    test_celebration();
    test_level_held();
    test_preempt();
    test_reset_mid();
`ifdef SFX_MUTE_EN
    test_mute();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
